// File: rtl/cacheline_mem_arbiter_if.sv
// Bundle of the icache, dcache and prefetcher request ports plus the 256-bit
// cacheline adaptor port served by cacheline_mem_arbiter.
interface cacheline_mem_arbiter_if;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;

  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;

  logic         pf_read;
  logic [31:0]  pf_address;
  logic [255:0] pf_rdata;
  logic         pf_resp;

  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  // The arbiter itself takes the slave view; requesters and adaptor take master.
  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    input  pf_read, pf_address,
    output pf_rdata, pf_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    output pf_read, pf_address,
    input  pf_rdata, pf_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates icache, dcache and prefetcher misses onto one cacheline adaptor.
// Demand wins over prefetch; a starvation counter eventually promotes prefetch.
module cacheline_mem_arbiter #(
  parameter int PF_STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  cacheline_mem_arbiter_if.slave bus
);

  localparam int CW = (PF_STARVE_LIMIT < 1) ? 1 : $clog2(PF_STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(PF_STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_D, G_I, G_PF} grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  logic          is_write_q, is_write_d;
  logic [31:0]   addr_q, addr_d;
  logic [255:0]  wdata_q, wdata_d;
  logic [255:0]  rdata_q, rdata_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          promote;

  assign promote = (PF_STARVE_LIMIT != 0) && bus.pf_read && (starve_q == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= G_NONE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    starve_d   = starve_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.pf_read) starve_d = '0;
        if (promote) begin
          grant_d    = G_PF;
          is_write_d = 1'b0;
          addr_d     = {bus.pf_address[31:5], 5'b0};
          starve_d   = '0;
          state_d    = BUSY;
        end else if (bus.d_read || bus.d_write) begin
          grant_d    = G_D;
          is_write_d = bus.d_write;
          addr_d     = {bus.d_address[31:5], 5'b0};
          if (bus.d_write) wdata_d = bus.d_wdata;
          if (bus.pf_read && (starve_q != LIMIT)) starve_d = starve_q + CW'(1);
          state_d    = BUSY;
        end else if (bus.i_read) begin
          grant_d    = G_I;
          is_write_d = 1'b0;
          addr_d     = {bus.i_address[31:5], 5'b0};
          if (bus.pf_read && (starve_q != LIMIT)) starve_d = starve_q + CW'(1);
          state_d    = BUSY;
        end else if (bus.pf_read) begin
          grant_d    = G_PF;
          is_write_d = 1'b0;
          addr_d     = {bus.pf_address[31:5], 5'b0};
          starve_d   = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // Writes leave the shared read-data register untouched.
        if (bus.mem_resp) begin
          if (!is_write_q) rdata_d = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = G_NONE;
      end
      default: begin
        state_d = IDLE;
        grant_d = G_NONE;
      end
    endcase
  end

  assign bus.mem_read    = (state_q == BUSY) && !is_write_q;
  assign bus.mem_write   = (state_q == BUSY) && is_write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

  assign bus.i_rdata  = rdata_q;
  assign bus.d_rdata  = rdata_q;
  assign bus.pf_rdata = rdata_q;
  assign bus.i_resp   = (state_q == RESP) && (grant_q == G_I);
  assign bus.d_resp   = (state_q == RESP) && (grant_q == G_D);
  assign bus.pf_resp  = (state_q == RESP) && (grant_q == G_PF);

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Scoreboard bench for cacheline_mem_arbiter: two instances (promotion limit 4
// and promotion disabled) share stimulus, one is observed at a time.
module tb_cacheline_mem_arbiter;

  localparam int LAT   = 4;
  localparam int D_ID  = 1;
  localparam int I_ID  = 2;
  localparam int PF_ID = 3;

  typedef struct packed {
    logic [1:0]   id;
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  always #5 clk = ~clk;

  logic         i_read, d_read, d_write, pf_read, mem_resp;
  logic [31:0]  i_address, d_address, pf_address;
  logic [255:0] d_wdata, mem_rdata;

  logic         fixed_data, inject_resp;
  int           checks = 0;
  int           failures = 0;
  exp_t         exp_q[$];

  cacheline_mem_arbiter_if bus4();
  cacheline_mem_arbiter_if bus0();

  cacheline_mem_arbiter #(.PF_STARVE_LIMIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  cacheline_mem_arbiter #(.PF_STARVE_LIMIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  assign bus4.i_read = i_read;         assign bus0.i_read = i_read;
  assign bus4.i_address = i_address;   assign bus0.i_address = i_address;
  assign bus4.d_read = d_read;         assign bus0.d_read = d_read;
  assign bus4.d_write = d_write;       assign bus0.d_write = d_write;
  assign bus4.d_address = d_address;   assign bus0.d_address = d_address;
  assign bus4.d_wdata = d_wdata;       assign bus0.d_wdata = d_wdata;
  assign bus4.pf_read = pf_read;       assign bus0.pf_read = pf_read;
  assign bus4.pf_address = pf_address; assign bus0.pf_address = pf_address;
  assign bus4.mem_rdata = mem_rdata;   assign bus0.mem_rdata = mem_rdata;
  assign bus4.mem_resp = mem_resp;     assign bus0.mem_resp = mem_resp;

  logic         m_read, m_write, m_i_resp, m_d_resp, m_pf_resp;
  logic [31:0]  m_address;
  logic [255:0] m_wdata, m_i_rdata, m_d_rdata, m_pf_rdata;

  assign m_read     = sel ? bus0.mem_read    : bus4.mem_read;
  assign m_write    = sel ? bus0.mem_write   : bus4.mem_write;
  assign m_address  = sel ? bus0.mem_address : bus4.mem_address;
  assign m_wdata    = sel ? bus0.mem_wdata   : bus4.mem_wdata;
  assign m_i_resp   = sel ? bus0.i_resp      : bus4.i_resp;
  assign m_d_resp   = sel ? bus0.d_resp      : bus4.d_resp;
  assign m_pf_resp  = sel ? bus0.pf_resp     : bus4.pf_resp;
  assign m_i_rdata  = sel ? bus0.i_rdata     : bus4.i_rdata;
  assign m_d_rdata  = sel ? bus0.d_rdata     : bus4.d_rdata;
  assign m_pf_rdata = sel ? bus0.pf_rdata    : bus4.pf_rdata;

  function automatic logic [255:0] memData(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_5A5A}};
  endfunction

  function automatic logic [255:0] wdataFor(input logic [31:0] a);
    return {8{a ^ 32'hDEAD_0000}};
  endfunction

  function automatic logic respOf(input int id);
    case (id)
      D_ID:    return m_d_resp;
      I_ID:    return m_i_resp;
      default: return m_pf_resp;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic expectGrant(input int id, input logic [31:0] raw, input logic wr);
    exp_t e;
    e.id    = 2'(id);
    e.addr  = {raw[31:5], 5'b0};
    e.wr    = wr;
    e.wdata = wr ? wdataFor(raw) : '0;
    e.rdata = fixed_data ? {32{8'hA5}} : memData(e.addr);
    exp_q.push_back(e);
  endtask

  task automatic waitResp(input int id);
    int cyc;
    logic ok;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      ok = respOf(id);
      cyc++;
    end
    checkOutput("resp_seen", 256'(ok), 256'(1));
  endtask

  task automatic waitMemRead();
    int cyc;
    cyc = 0;
    while (!m_read && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("mem_read_seen", 256'(m_read), 256'(1));
  endtask

  // One requester: issues n back-to-back requests, re-asserting right after each resp.
  task automatic applyStimulus(input int id, input int n, input logic wr, input logic [31:0] base);
    logic [31:0] a;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      a = base + 32'(k) * 32'h40;
      case (id)
        D_ID:    begin d_address = a; d_write = wr; d_read = !wr; d_wdata = wdataFor(a); end
        I_ID:    begin i_address = a; i_read = 1'b1; end
        default: begin pf_address = a; pf_read = 1'b1; end
      endcase
      waitResp(id);
      @(posedge clk); #1;
    end
    case (id)
      D_ID:    begin d_read = 1'b0; d_write = 1'b0; end
      I_ID:    i_read = 1'b0;
      default: pf_read = 1'b0;
    endcase
  endtask

  // Adaptor model: answers LAT cycles into a request, plus optional stray pulses.
  initial begin
    int  lat_cnt;
    logic served;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    lat_cnt   = 0;
    served    = 1'b0;
    forever begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (inject_resp) begin
        mem_resp    = 1'b1;
        mem_rdata   = {32{8'h3C}};
        inject_resp = 1'b0;
      end else if (!rst && (m_read || m_write)) begin
        if (!served) begin
          lat_cnt++;
          if (lat_cnt == LAT) begin
            mem_resp = 1'b1;
            served   = 1'b1;
            if (m_read) mem_rdata = fixed_data ? {32{8'hA5}} : memData(m_address);
          end
        end
      end else begin
        lat_cnt = 0;
        served  = 1'b0;
      end
    end
  end

  // Monitor: checks each grant against the queue head, pops on each resp.
  initial begin
    logic in_txn;
    exp_t e;
    int   nresp;
    int   got_id;
    in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 1'b0;
      end else begin
        if ((m_read || m_write) && !in_txn) begin
          in_txn = 1'b1;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_grant", 256'(m_address), '1);
          end else begin
            e = exp_q[0];
            checkOutput("grant_addr", 256'(m_address), 256'(e.addr));
            checkOutput("grant_write", 256'({m_read, m_write}), 256'({!e.wr, e.wr}));
            if (e.wr) checkOutput("grant_wdata", m_wdata, e.wdata);
          end
        end
        if (!(m_read || m_write)) in_txn = 1'b0;
        nresp = int'(m_i_resp) + int'(m_d_resp) + int'(m_pf_resp);
        if (nresp != 0) begin
          checkOutput("resp_onehot", 256'(nresp), 256'(1));
          got_id = m_d_resp ? D_ID : (m_i_resp ? I_ID : PF_ID);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_resp", 256'(got_id), 256'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("resp_id", 256'(got_id), 256'(e.id));
            if (!e.wr) begin
              case (got_id)
                D_ID:    checkOutput("resp_rdata", m_d_rdata, e.rdata);
                I_ID:    checkOutput("resp_rdata", m_i_rdata, e.rdata);
                default: checkOutput("resp_rdata", m_pf_rdata, e.rdata);
              endcase
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; fixed_data = 1'b0; inject_resp = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pf_read = 1'b0;
    i_address = '0; d_address = '0; pf_address = '0; d_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_rw", 256'({m_read, m_write}), 256'(0));
    checkOutput("rst_resp", 256'({m_i_resp, m_d_resp, m_pf_resp}), 256'(0));
    checkOutput("rst_mem_address", 256'(m_address), 256'(0));
    checkOutput("rst_rdata", m_pf_rdata, 256'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single prefetch with a fixed data pattern.
    fixed_data = 1'b1;
    expectGrant(PF_ID, 32'h0000_1234, 1'b0);
    @(posedge clk); #1;
    pf_read = 1'b1; pf_address = 32'h0000_1234;
    @(posedge clk); @(negedge clk);
    checkOutput("pf_mem_read", 256'({m_read, m_address}), 256'({1'b1, 32'h0000_1220}));
    waitResp(PF_ID);
    @(posedge clk); #1 pf_read = 1'b0;
    @(negedge clk);
    checkOutput("pf_rdata_hold", m_pf_rdata, {32{8'hA5}});
    fixed_data = 1'b0;

    // Priority with all three asserted together.
    expectGrant(D_ID, 32'h1000_0007, 1'b1);
    expectGrant(I_ID, 32'h2000_0007, 1'b0);
    expectGrant(PF_ID, 32'h3000_0007, 1'b0);
    fork
      applyStimulus(D_ID, 1, 1'b1, 32'h1000_0007);
      applyStimulus(I_ID, 1, 1'b0, 32'h2000_0007);
      applyStimulus(PF_ID, 1, 1'b0, 32'h3000_0007);
    join

    // Stray mem_resp in IDLE.
    @(posedge clk); #1 inject_resp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("spurious_resp", 256'({m_i_resp, m_d_resp, m_pf_resp, m_read, m_write}), 256'(0));
    end

    // d_address moving while BUSY.
    expectGrant(D_ID, 32'h4000_0007, 1'b0);
    @(posedge clk); #1 d_read = 1'b1; d_address = 32'h4000_0007;
    waitMemRead();
    @(posedge clk); #1 d_address = 32'h5555_5547;
    @(negedge clk);
    checkOutput("busy_addr_hold", 256'(m_address), 256'(32'h4000_0000));
    waitResp(D_ID);
    @(posedge clk); #1 d_read = 1'b0;

    // Starvation promotion at limit 4: 5th grant is PF.
    for (int k = 0; k < 4; k++) expectGrant(D_ID, 32'h1100_0007 + 32'(k) * 32'h40, 1'b0);
    expectGrant(PF_ID, 32'h3100_0007, 1'b0);
    for (int k = 4; k < 6; k++) expectGrant(D_ID, 32'h1100_0007 + 32'(k) * 32'h40, 1'b0);
    for (int k = 0; k < 2; k++) expectGrant(I_ID, 32'h2100_0007 + 32'(k) * 32'h40, 1'b0);
    fork
      applyStimulus(D_ID, 6, 1'b0, 32'h1100_0007);
      applyStimulus(I_ID, 2, 1'b0, 32'h2100_0007);
      applyStimulus(PF_ID, 1, 1'b0, 32'h3100_0007);
    join
    @(negedge clk);
    checkOutput("starve_cleared", 256'(dut4.starve_q), 256'(0));
    checkOutput("starve_queue_empty", 256'(exp_q.size()), 256'(0));

    // Same stimulus with promotion disabled: PF waits for demand to drain.
    @(posedge clk); #1 rst = 1'b1; sel = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) expectGrant(D_ID, 32'h1100_0007 + 32'(k) * 32'h40, 1'b0);
    for (int k = 0; k < 2; k++) expectGrant(I_ID, 32'h2100_0007 + 32'(k) * 32'h40, 1'b0);
    expectGrant(PF_ID, 32'h3100_0007, 1'b0);
    fork
      applyStimulus(D_ID, 6, 1'b0, 32'h1100_0007);
      applyStimulus(I_ID, 2, 1'b0, 32'h2100_0007);
      applyStimulus(PF_ID, 1, 1'b0, 32'h3100_0007);
    join
    @(posedge clk); #1 rst = 1'b1; sel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Async reset mid-BUSY abandons the transaction; a fresh grant follows.
    expectGrant(PF_ID, 32'h3200_0007, 1'b0);
    @(posedge clk); #1 pf_read = 1'b1; pf_address = 32'h3200_0007;
    waitMemRead();
    @(negedge clk); #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_mem_read", 256'({m_read, m_write}), 256'(0));
    checkOutput("rst_async_resp", 256'({m_i_resp, m_d_resp, m_pf_resp}), 256'(0));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    waitResp(PF_ID);
    @(posedge clk); #1 pf_read = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
